ysyx_24090012_ifu: RTL and testbench

Instruction fetch unit: the upstream end of the IFU→IDU valid/ready link. It holds the architectural PC, issues one read per instruction on an AXI-lite-style read channel, and presents the returned instruction word with its PC to the decode stage. It then waits for the next PC from writeback, so exactly one instruction is in flight. It also keeps fetch performance counters and reports sticky fetch faults.

---
 rtl/ysyx_24090012_ifu.sv | 142 ++++++++++++++
 tb/tb_ysyx_24090012_ifu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090012_ifu.sv
// rtl/ysyx_24090012_ifu.sv - single-outstanding instruction fetch unit with fault capture and counters
// One read per instruction; the next PC always comes back from writeback before the next fetch.
module ysyx_24090012_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clock,
   input  logic             reset,
   output logic [31:0]      araddr,
   output logic             arvalid,
   input  logic             arready,
   input  logic [31:0]      rdata,
   input  logic [1:0]       rresp,
   input  logic             rvalid,
   output logic             rready,
   output logic [31:0]      inst,
   output logic [31:0]      ifu_to_idu_pc,
   output logic             ifu_valid,
   input  logic             ifu_ready,
   input  logic [31:0]      npc,
   input  logic             npc_valid,
   output logic             npc_ready,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [31:0]      fault_pc,
   output logic [CNT_W-1:0] fetch_count,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [2:0] {
      S_REQ     = 3'd0,
      S_WAIT_R  = 3'd1,
      S_VALID   = 3'd2,
      S_WAIT_PC = 3'd3,
      S_FAULT   = 3'd4
   } state_e;

   localparam logic [1:0] CAUSE_BUS   = 2'b01;
   localparam logic [1:0] CAUSE_ALIGN = 2'b10;

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic [1:0]       fault_cause_q, fault_cause_d;
   logic [31:0]      fault_pc_q, fault_pc_d;
   logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         inst_q        <= 32'd0;
         fault_cause_q <= 2'b00;
         fault_pc_q    <= 32'd0;
         fetch_cnt_q   <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         fault_cause_q <= fault_cause_d;
         fault_pc_q    <= fault_pc_d;
         fetch_cnt_q   <= fetch_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      fault_cause_d = fault_cause_q;
      fault_pc_d    = fault_pc_q;
      fetch_cnt_d   = fetch_cnt_q;
      stall_cnt_d   = stall_cnt_q;

      if (state_q == S_REQ || state_q == S_WAIT_R) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      case (state_q)
         // A data beat coinciding with address acceptance is ignored here.
         S_REQ: begin
            if (arready) begin
               state_d = S_WAIT_R;
            end
         end
         S_WAIT_R: begin
            if (rvalid) begin
               if (rresp == 2'b00) begin
                  inst_d  = rdata;
                  state_d = S_VALID;
               end else begin
                  fault_cause_d = CAUSE_BUS;
                  fault_pc_d    = pc_q;
                  state_d       = S_FAULT;
               end
            end
         end
         S_VALID: begin
            if (ifu_ready) begin
               fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
               state_d     = S_WAIT_PC;
            end
         end
         S_WAIT_PC: begin
            if (npc_valid) begin
               if (npc[1:0] == 2'b00) begin
                  pc_d    = npc;
                  state_d = S_REQ;
               end else begin
                  fault_cause_d = CAUSE_ALIGN;
                  fault_pc_d    = npc;
                  state_d       = S_FAULT;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FAULT;
         end
      endcase
   end

   // Instruction and its PC are only presented while the IDU handshake is open.
   assign araddr        = pc_q;
   assign arvalid       = (state_q == S_REQ);
   assign rready        = (state_q == S_WAIT_R);
   assign ifu_valid     = (state_q == S_VALID);
   assign inst          = (state_q == S_VALID) ? inst_q : 32'd0;
   assign ifu_to_idu_pc = (state_q == S_VALID) ? pc_q : 32'd0;
   assign npc_ready     = (state_q == S_WAIT_PC);
   assign fault         = (state_q == S_FAULT);
   assign fault_cause   = fault_cause_q;
   assign fault_pc      = fault_pc_q;
   assign fetch_count   = fetch_cnt_q;
   assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// tb/tb_ysyx_24090012_ifu.sv - directed bench with a handshake-level reference model
module tb_ysyx_24090012_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] ifu_to_idu_pc;
   logic        ifu_valid;
   logic        ifu_ready;
   logic [31:0] npc;
   logic        npc_valid;
   logic        npc_ready;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   int n_cmp = 0;
   int n_bad = 0;

   ysyx_24090012_ifu #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .clock(clock), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .inst(inst), .ifu_to_idu_pc(ifu_to_idu_pc), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
      .npc(npc), .npc_valid(npc_valid), .npc_ready(npc_ready),
      .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc),
      .fetch_count(fetch_count), .stall_count(stall_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model tracks which handshake is open and what has been accepted so far.
   logic        m_ok = 1'b0;
   logic        m_ar, m_r, m_iv, m_np, m_flt;
   logic [31:0] m_pc, m_inst, m_fpc, m_fetch, m_stall;
   logic [1:0]  m_cause;

   always @(posedge clock) begin
      if (!reset) begin
         m_ok = 1'b1; m_ar = 1'b1; m_r = 1'b0; m_iv = 1'b0; m_np = 1'b0; m_flt = 1'b0;
         m_pc = RST_PC; m_inst = 0; m_fpc = 0; m_fetch = 0; m_stall = 0; m_cause = 0;
      end else if (m_ok) begin
         if (m_ar || m_r) m_stall = m_stall + 1;
         if (m_ar) begin
            if (arready) begin m_ar = 1'b0; m_r = 1'b1; end
         end else if (m_r) begin
            if (rvalid) begin
               m_r = 1'b0;
               if (rresp == 2'b00) begin m_iv = 1'b1; m_inst = rdata; end
               else begin m_flt = 1'b1; m_cause = 2'b01; m_fpc = m_pc; end
            end
         end else if (m_iv) begin
            if (ifu_ready) begin m_iv = 1'b0; m_np = 1'b1; m_fetch = m_fetch + 1; end
         end else if (m_np) begin
            if (npc_valid) begin
               m_np = 1'b0;
               if (npc[1:0] == 2'b00) begin m_pc = npc; m_ar = 1'b1; end
               else begin m_flt = 1'b1; m_cause = 2'b10; m_fpc = npc; end
            end
         end
      end
   end

   always @(negedge clock) begin
      if (m_ok) begin
         chk("arvalid", 32'(arvalid), 32'(m_ar));
         chk("rready", 32'(rready), 32'(m_r));
         chk("ifu_valid", 32'(ifu_valid), 32'(m_iv));
         chk("npc_ready", 32'(npc_ready), 32'(m_np));
         chk("fault", 32'(fault), 32'(m_flt));
         chk("fault_cause", 32'(fault_cause), 32'(m_cause));
         chk("fault_pc", fault_pc, m_fpc);
         chk("fetch_count", fetch_count, m_fetch);
         chk("stall_count", stall_count, m_stall);
         if (m_ar) chk("araddr", araddr, m_pc);
         if (m_iv) begin
            chk("inst", inst, m_inst);
            chk("ifu_to_idu_pc", ifu_to_idu_pc, m_pc);
         end
      end
   end

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic clear_in();
      arready = 0; rvalid = 0; rresp = 0; rdata = 0; ifu_ready = 0; npc_valid = 0; npc = 0;
   endtask

   initial begin
      reset = 0;
      clear_in();
      repeat (3) cyc();
      reset = 1;
      #1;
      chk("boot_arvalid", 32'(arvalid), 32'd1);
      chk("boot_araddr", araddr, 32'h8000_0000);
      chk("boot_fetch", fetch_count, 32'd0);
      chk("boot_stall", stall_count, 32'd0);
      chk("boot_ifu_valid", 32'(ifu_valid), 32'd0);
      chk("boot_fault", 32'(fault), 32'd0);

      // zero-wait fetch
      arready = 1; cyc();
      arready = 0; rvalid = 1; rdata = 32'h0010_0093; cyc();
      rvalid = 0; #1;
      chk("zw_valid", 32'(ifu_valid), 32'd1);
      chk("zw_inst", inst, 32'h0010_0093);
      chk("zw_pc", ifu_to_idu_pc, 32'h8000_0000);
      ifu_ready = 1; cyc();
      ifu_ready = 0; npc = 32'h8000_0004; npc_valid = 1; cyc();
      npc_valid = 0; #1;
      chk("zw_araddr", araddr, 32'h8000_0004);
      chk("zw_arvalid", 32'(arvalid), 32'd1);
      chk("zw_fetch", fetch_count, 32'd1);
      chk("zw_stall", stall_count, 32'd2);
      chk("model_stall", m_stall, 32'd2);
      chk("model_fetch", m_fetch, 32'd1);

      // backpressure with noise on the other channels
      arready = 1; cyc();
      arready = 0; rvalid = 1; rdata = 32'h0020_8113; cyc();
      for (int i = 0; i < 5; i++) begin
         rvalid = 1; rdata = $urandom; npc_valid = 1; npc = 32'h0000_1234;
         cyc();
         #1;
         chk("bp_inst", inst, 32'h0020_8113);
         chk("bp_pc", ifu_to_idu_pc, 32'h8000_0004);
         chk("bp_no_read", 32'(arvalid), 32'd0);
      end
      clear_in();
      ifu_ready = 1; cyc();
      ifu_ready = 0; npc = 32'h8000_0008; npc_valid = 1; cyc();
      npc_valid = 0; #1;
      chk("bp_araddr", araddr, 32'h8000_0008);
      chk("bp_fetch", fetch_count, 32'd2);
      chk("bp_stall", stall_count, 32'd4);

      // misaligned npc
      arready = 1; cyc();
      arready = 0; rvalid = 1; rdata = 32'h0000_0013; cyc();
      rvalid = 0; ifu_ready = 1; cyc();
      ifu_ready = 0; npc = 32'h8000_0006; npc_valid = 1; cyc();
      npc_valid = 0; #1;
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_cause", 32'(fault_cause), 32'd2);
      chk("mis_fpc", fault_pc, 32'h8000_0006);
      chk("mis_arvalid", 32'(arvalid), 32'd0);
      arready = 1; rvalid = 1; ifu_ready = 1; npc_valid = 1; npc = 32'h8000_0010;
      repeat (3) cyc();
      #1;
      chk("mis_sticky", 32'(fault), 32'd1);
      chk("mis_quiet", 32'({arvalid, rready, ifu_valid, npc_ready}), 32'd0);
      clear_in();

      // bus error
      reset = 0; cyc();
      reset = 1; #1;
      chk("be_cleared", 32'({fault, fault_cause}), 32'd0);
      arready = 1; cyc();
      arready = 0; rvalid = 1; rresp = 2'b10; rdata = 32'hFFFF_FFFF; cyc();
      rvalid = 0; rresp = 0; #1;
      chk("be_fault", 32'(fault), 32'd1);
      chk("be_cause", 32'(fault_cause), 32'd1);
      chk("be_fpc", fault_pc, 32'h8000_0000);
      chk("be_ifu_valid", 32'(ifu_valid), 32'd0);
      arready = 1; rvalid = 1; ifu_ready = 1;
      repeat (3) cyc();
      #1;
      chk("be_sticky", 32'(fault), 32'd1);
      chk("be_never_valid", 32'(ifu_valid), 32'd0);
      clear_in();

      // reset while waiting for read data
      reset = 0; cyc();
      reset = 1; arready = 1; cyc();
      arready = 0; reset = 0; cyc();
      reset = 1; #1;
      chk("rm_arvalid", 32'(arvalid), 32'd1);
      chk("rm_araddr", araddr, RST_PC);
      chk("rm_counts", fetch_count | stall_count, 32'd0);
      rvalid = 1; rdata = 32'hDEAD_BEEF; cyc();
      rvalid = 0; #1;
      chk("rm_late_ignored", 32'(ifu_valid), 32'd0);
      chk("rm_still_req", 32'(arvalid), 32'd1);
      arready = 1; cyc();
      arready = 0; rvalid = 1; rdata = 32'h0000_0013; cyc();
      rvalid = 0; #1;
      chk("rm_refetch_inst", inst, 32'h0000_0013);
      chk("rm_refetch_pc", ifu_to_idu_pc, RST_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
